// File: rtl/frame_streamer.sv
// frame_streamer: frame RAM loaded through a host write port and replayed as a
// raster pixel stream (row-major, one pixel per cycle), followed by a flush
// window and a one-cycle frame_done pulse.
// Optional feature macro: ROW_GAP_EN inserts ROW_GAP idle cycles after every
// row except the last one.
//
// Stream handshake: pixel_valid qualifies pixel_out, row_idx and col_idx for
// exactly the cycle it is high. hold is sampled at the rising edge and, when
// high, blocks the pixel issue at that edge (pixel_valid is low the following
// cycle and pixel_out keeps its previous value). There is no other
// backpressure; abort overrides hold.
module frame_streamer #(
    parameter int IMG_WIDTH    = 28,
    parameter int IMG_HEIGHT   = 28,
    parameter int DATA_WIDTH   = 8,
    parameter int FLUSH_CYCLES = 5,
    parameter int ROW_GAP      = 2,
    localparam int NPIX        = IMG_WIDTH * IMG_HEIGHT,
    localparam int AW          = $clog2(NPIX),
    localparam int RW          = $clog2(IMG_HEIGHT),
    localparam int CW          = $clog2(IMG_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    input  logic                  hold,
    input  logic                  abort,
    output logic [DATA_WIDTH-1:0] pixel_out,
    output logic                  pixel_valid,
    output logic [RW-1:0]         row_idx,
    output logic [CW-1:0]         col_idx,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  load_err
);

    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    localparam logic [AW-1:0] LAST_PTR   = AW'(NPIX - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_HEIGHT - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [DATA_WIDTH-1:0] mem [NPIX];

    logic [AW-1:0] rd_ptr;
    logic [RW-1:0] row_cnt;
    logic [CW-1:0] col_cnt;
    logic [FW-1:0] flush_cnt;

    logic issue;       // a pixel is read out at this edge
    logic gap_active;  // inside an inter-row gap
    logic kill;        // abort that actually terminates a frame
    logic wr_ok;       // host write accepted into the RAM
    logic restart;     // start accepted in IDLE

    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);
    assign kill       = abort && ((state_q == STREAM) || (state_q == FLUSH));
    assign restart    = (state_q == IDLE) && start;
    assign wr_ok      = wr_en && (state_q == IDLE) && (32'(wr_addr) < NPIX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and pixel-issue decision
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!hold && !gap_active) begin
                    issue = 1'b1;
                    if (rd_ptr == LAST_PTR) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // FLUSH is entered on the edge that issues the last pixel, so
                // it lasts FLUSH_CYCLES+1 cycles: one with the last pixel
                // valid plus FLUSH_CYCLES idle ones.
                if (abort) begin
                    state_d = IDLE;
                end else if (flush_cnt == FLUSH_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Frame RAM write port; no reset so contents survive rst_n
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output registers: synchronous RAM read lands directly in pixel_out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_out   <= '0;
            pixel_valid <= 1'b0;
            row_idx     <= '0;
            col_idx     <= '0;
            load_err    <= 1'b0;
        end else begin
            pixel_valid <= issue;
            load_err    <= wr_en && busy;
            if (issue) begin
                pixel_out <= mem[rd_ptr];
                row_idx   <= row_cnt;
                col_idx   <= col_cnt;
            end
        end
    end

    // Read pointer and raster coordinates of the next pixel to issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            row_cnt <= '0;
            col_cnt <= '0;
        end else if (kill || restart) begin
            rd_ptr  <= '0;
            row_cnt <= '0;
            col_cnt <= '0;
        end else if (issue) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (col_cnt == COL_LAST) begin
                col_cnt <= '0;
                row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    // Flush window counter, zero whenever not staying in FLUSH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt <= '0;
        end else if ((state_q == FLUSH) && (state_d == FLUSH)) begin
            flush_cnt <= flush_cnt + 1'b1;
        end else begin
            flush_cnt <= '0;
        end
    end

`ifdef ROW_GAP_EN
    localparam int GW = (ROW_GAP > 0) ? $clog2(ROW_GAP + 1) : 1;

    logic [GW-1:0] gap_cnt;

    assign gap_active = (gap_cnt != '0);

    // Inter-row gap: loaded when the last column of a non-final row issues,
    // then counts down regardless of hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if (kill || (state_q != STREAM)) begin
            gap_cnt <= '0;
        end else if (gap_active) begin
            gap_cnt <= gap_cnt - 1'b1;
        end else if (issue && (col_cnt == COL_LAST) && (row_cnt != ROW_LAST)) begin
            gap_cnt <= GW'(ROW_GAP);
        end
    end
`else
    // Gaps compiled out: false for every legal (non-negative) ROW_GAP
    assign gap_active = (ROW_GAP < 0);
`endif

endmodule

// File: tb/tb_frame_streamer.sv
// tb_frame_streamer: table of frame scenarios (hold pattern, abort point,
// busy-time pokes) replayed against a reference model built from a plain
// array image of the frame RAM, plus hand-written reset sequences.
module tb_frame_streamer;

  localparam int W     = 28;
  localparam int H     = 28;
  localparam int DW    = 8;
  localparam int FC    = 5;
  localparam int RG    = 2;
  localparam int NPIX  = W * H;
  localparam int AW    = $clog2(NPIX);
  localparam int RW    = $clog2(H);
  localparam int CW    = $clog2(W);
`ifdef ROW_GAP_EN
  localparam int GAP   = RG;
`else
  localparam int GAP   = 0;
`endif
  localparam int FRAME_BUDGET = 3 * NPIX + H * RG + 100;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic          hold;
  logic          abort;
  logic [DW-1:0] pixel_out;
  logic          pixel_valid;
  logic [RW-1:0] row_idx;
  logic [CW-1:0] col_idx;
  logic          busy;
  logic          frame_done;
  logic          load_err;

  frame_streamer #(
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .DATA_WIDTH  (DW),
    .FLUSH_CYCLES(FC),
    .ROW_GAP     (RG)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .hold       (hold),
    .abort      (abort),
    .pixel_out  (pixel_out),
    .pixel_valid(pixel_valid),
    .row_idx    (row_idx),
    .col_idx    (col_idx),
    .busy       (busy),
    .frame_done (frame_done),
    .load_err   (load_err)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] ref_mem [NPIX];   // model of the frame RAM contents
  logic [DW-1:0] exp_q[$];         // scoreboard: expected pixel stream

  typedef struct {
    int hold_mode;   // 0 = never, 1 = toggle every cycle, 2 = random
    int abort_at;    // pixel index on pixel_out when abort is raised, -1 none
    int poke_at;     // pixel index at which busy-time write/start is attempted
    bit reload;      // reload RAM with random data first
    int exp_pixels;
    bit exp_done;
  } frame_vec_t;

  frame_vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pixel_out"}, 32'(pixel_out), 0);
    check({tag, "_pixel_valid"}, 32'(pixel_valid), 0);
    check({tag, "_row_idx"}, 32'(row_idx), 0);
    check({tag, "_col_idx"}, 32'(col_idx), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_frame_done"}, 32'(frame_done), 0);
    check({tag, "_load_err"}, 32'(load_err), 0);
  endtask

  // driver: single host write, with load_err checked one cycle later
  task automatic host_write_dropped(input int addr, input logic [DW-1:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = AW'(addr); wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    check("oob_write_no_load_err", 32'(load_err), 0);
  endtask

  // driver: fill the whole frame RAM while idle
  task automatic load_frame(input bit rnd);
    int errs = 0;
    for (int i = 0; i < NPIX; i++) begin
      @(negedge clk);
      if (i > 0 && load_err) errs++;
      wr_en   = 1'b1;
      wr_addr = AW'(i);
      wr_data = rnd ? DW'($urandom_range(0, 255)) : DW'(i % 256);
      ref_mem[i] = wr_data;
    end
    @(negedge clk);
    if (load_err) errs++;
    wr_en = 1'b0;
    check("load_no_err", 32'(errs), 0);
  endtask

  // driver + monitor for one frame scenario
  task automatic run_frame(input frame_vec_t v);
    int n = 0;
    int cyc = 0;
    int first_cyc = -1;
    int last_cyc = -1;
    int done_cyc = -1;
    int done_cnt = 0;
    int abort_cyc = -1;
    int poke_cyc = -1;
    int timing_err = 0;
    int b2b = 0;
    int exp_cyc;
    bit prev_valid = 1'b0;
    bit finished = 1'b0;
    logic [DW-1:0] exp_pix;

    if (v.reload) load_frame(1'b1);
    exp_q.delete();
    for (int i = 0; i < NPIX; i++) exp_q.push_back(ref_mem[i]);

    @(negedge clk);
    start = 1'b1; hold = 1'b0; abort = 1'b0;
    while (!finished && cyc < FRAME_BUDGET) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; wr_en = 1'b0; abort = 1'b0;

      if (pixel_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_pixel", 1, 0);
        end else begin
          exp_pix = exp_q.pop_front();
          check("pixel_out", 32'(pixel_out), 32'(exp_pix));
          check("row_idx", 32'(row_idx), n / W);
          check("col_idx", 32'(col_idx), n % W);
        end
        if (first_cyc < 0) first_cyc = cyc;
        if (v.hold_mode == 0) begin
          exp_cyc = 2 + n + (n / W) * GAP;
          if (cyc != exp_cyc) timing_err++;
        end
        if (prev_valid) b2b++;
        last_cyc = cyc;
        n++;
      end
      prev_valid = pixel_valid;

      if (frame_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (poke_cyc >= 0 && cyc == poke_cyc + 1) check("busy_write_load_err", 32'(load_err), 1);
      if (poke_cyc >= 0 && cyc == poke_cyc + 2) check("load_err_one_cycle", 32'(load_err), 0);
      if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
        check("abort_valid_low", 32'(pixel_valid), 0);
        check("abort_busy_low", 32'(busy), 0);
      end
      if (abort_cyc >= 0 && cyc == abort_cyc + 4) finished = 1'b1;
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        check("idle_after_done", 32'(busy), 0);
        finished = 1'b1;
      end

      // stimulus for the next edge
      case (v.hold_mode)
        1:       hold = (cyc % 2 == 1);
        2:       hold = 1'($urandom_range(0, 1));
        default: hold = 1'b0;
      endcase
      if (pixel_valid && abort_cyc < 0 && (n - 1) == v.abort_at) begin
        abort = 1'b1;
        abort_cyc = cyc;
        if (v.hold_mode == 2) hold = 1'b1;
      end
      if (pixel_valid && poke_cyc < 0 && (n - 1) == v.poke_at) begin
        wr_en = 1'b1; wr_addr = AW'(10); wr_data = 8'hFF; start = 1'b1;
        poke_cyc = cyc;
      end
      if (frame_done && v.poke_at >= 0) start = 1'b1;
    end
    start = 1'b0; hold = 1'b0; abort = 1'b0; wr_en = 1'b0;

    check("frame_finished", 32'(finished), 1);
    check("pixel_count", n, v.exp_pixels);
    check("done_count", done_cnt, v.exp_done ? 1 : 0);
    if (v.exp_done) check("flush_to_done", done_cyc - last_cyc, FC + 1);
    if (v.hold_mode == 0) check("pixel_timing_errs", timing_err, 0);
    if (v.hold_mode == 0 && v.exp_done)
      check("frame_span", last_cyc - first_cyc + 1, NPIX + (H - 1) * GAP);
    if (v.hold_mode == 1) check("toggle_back_to_back", b2b, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit seen;
    frame_vec_t basic;

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; hold = 1'b0; abort = 1'b0;

    vecs[0] = '{0, -1,       -1, 1'b0, NPIX, 1'b1};  // basic frame
    vecs[1] = '{1, -1,       -1, 1'b0, NPIX, 1'b1};  // hold toggling
    vecs[2] = '{0, -1,       50, 1'b0, NPIX, 1'b1};  // busy write/start pokes
    vecs[3] = '{2, -1,       -1, 1'b0, NPIX, 1'b1};  // random hold, RAM intact
    vecs[4] = '{0, 100,      -1, 1'b0, 101,  1'b0};  // abort at pixel 100
    vecs[5] = '{0, -1,       -1, 1'b0, NPIX, 1'b1};  // restart after abort
    vecs[6] = '{2, NPIX - 1, -1, 1'b0, NPIX, 1'b0};  // abort during flush
    vecs[7] = '{1, 0,        -1, 1'b0, 1,    1'b0};  // abort at first pixel
    vecs[8] = '{2, -1,       -1, 1'b1, NPIX, 1'b1};  // random data and hold
    basic   = vecs[0];

    repeat (3) @(negedge clk);
    check_all_zero("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("after_reset");

    host_write_dropped(NPIX, 8'h55);
    host_write_dropped((1 << AW) - 1, 8'h66);
    load_frame(1'b0);

    for (int i = 0; i < 9; i++) run_frame(vecs[i]);

    // reset in the middle of a stream
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    seen = 1'b0;
    for (int c = 0; c < FRAME_BUDGET && !seen; c++) begin
      @(negedge clk);
      if (pixel_valid) begin
        if (cnt == 300) seen = 1'b1;
        cnt++;
      end
    end
    check("reached_pixel_300", 32'(seen), 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_stream_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(basic);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
